// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its consumers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    // Width of the IF/ID payload fields, shared with the decode stage.
    localparam int XLEN = 32;

    // PC advance per fetched word, and the R15 read offset seen by decode.
    localparam int unsigned PC_STEP        = 4;
    localparam int unsigned PC_READ_OFFSET = 8;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // IF/ID register contents: instruction word and the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } ifid_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry IF/ID-shaped holding buffer with load, unload and clear.
// Latency: loaded entry is visible on skid_dat the cycle after load.
// Backpressure: none of its own; the owner only loads when the entry is free.
module fetch_skid
    import fetch_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  unload,
    input  logic  clear,
    input  ifid_t load_dat,
    output logic  skid_vld,
    output ifid_t skid_dat
);

    logic  skid_vld_q, skid_vld_d;
    ifid_t skid_dat_q, skid_dat_d;

    // Next entry: clear beats load, load beats unload.
    always_comb begin
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        if (clear) begin
            skid_vld_d = 1'b0;
            skid_dat_d = '0;
        end else if (load) begin
            skid_vld_d = 1'b1;
            skid_dat_d = load_dat;
        end else if (unload) begin
            skid_vld_d = 1'b0;
            skid_dat_d = '0;
        end
    end

    // Entry register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
        end else begin
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
        end
    end

    assign skid_vld = skid_vld_q;
    assign skid_dat = skid_dat_q;

endmodule

// File: rtl/fetch_stage.sv
// ARMv4 instruction fetch: owns the PC, fetches over req/ack, fills the IF/ID register.
// Latency: a word acked in cycle N is in IF/ID in cycle N+1; 1 instr/cycle with zero-wait memory.
// Backpressure: stall freezes IF/ID; one fetch landing under stall parks in the skid and req drops.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int          BUS      = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic           imem_req,
    output logic [BUS-1:0] imem_addr,
    input  logic           imem_ack,
    input  logic [BUS-1:0] imem_rdata,
    input  logic           stall,
    input  logic           redirect_valid,
    input  logic [BUS-1:0] redirect_pc,
    output logic           if_valid,
    output logic [BUS-1:0] if_instr,
    output logic [BUS-1:0] if_pc,
    output logic [BUS-1:0] if_pc_plus8
);

    fetch_state_t   state_q, state_d;
    logic [BUS-1:0] pc_q, pc_d;
    logic [BUS-1:0] drain_addr_q, drain_addr_d;
    ifid_t          ifid_q, ifid_d;
    logic           if_valid_q, if_valid_d;

    logic           skid_load, skid_unload, skid_clear;
    logic           skid_vld;
    ifid_t          skid_dat;
    ifid_t          fetch_word;
    logic [BUS-1:0] pc_next;
    logic [BUS-1:0] redirect_tgt;

    // Targets are word aligned; the low two bits are deliberately dropped.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign fetch_word   = '{instr: imem_rdata, pc: pc_q};
    assign pc_next      = pc_q + BUS'(PC_STEP);
    assign redirect_tgt = {redirect_pc[BUS-1:2], 2'b00};

    fetch_skid u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (skid_load),
        .unload   (skid_unload),
        .clear    (skid_clear),
        .load_dat (fetch_word),
        .skid_vld (skid_vld),
        .skid_dat (skid_dat)
    );

    // Next state, PC, IF/ID and skid control; redirect overrides everything.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        ifid_d       = ifid_q;
        if_valid_d   = if_valid_q;
        skid_load    = 1'b0;
        skid_unload  = 1'b0;
        skid_clear   = 1'b0;

        if (redirect_valid) begin
            if_valid_d = 1'b0;
            skid_clear = 1'b1;
            pc_d       = redirect_tgt;
            unique case (state_q)
                FETCH: begin
                    // Request still outstanding: remember its address and drop its data later.
                    if (!imem_ack) begin
                        state_d      = DRAIN;
                        drain_addr_d = pc_q;
                    end
                end
                HOLD:  state_d = FETCH;
                // An ack arriving with the redirect retires the old request right now.
                DRAIN: if (imem_ack) state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (imem_ack) begin
                        pc_d = pc_next;
                        if (!if_valid_q || !stall) begin
                            ifid_d     = fetch_word;
                            if_valid_d = 1'b1;
                        end else begin
                            skid_load = 1'b1;
                            state_d   = HOLD;
                        end
                    end else if (!stall) begin
                        if_valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifid_d      = skid_dat;
                        if_valid_d  = skid_vld;
                        skid_unload = 1'b1;
                        state_d     = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_ack) state_d = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // Stage state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            pc_q         <= BUS'(RESET_PC);
            drain_addr_q <= '0;
            ifid_q       <= '0;
            if_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            ifid_q       <= ifid_d;
            if_valid_q   <= if_valid_d;
        end
    end

    // Request is gated by reset so it is low for the whole reset pulse.
    assign imem_req    = rst_n && (state_q != HOLD);
    assign imem_addr   = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign if_valid    = if_valid_q;
    assign if_instr    = ifid_q.instr;
    assign if_pc       = ifid_q.pc;
    assign if_pc_plus8 = ifid_q.pc + BUS'(PC_READ_OFFSET);

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr, if_pc, if_pc_plus8;

    logic        wrap_req, wrap_valid;
    logic [31:0] wrap_addr, wrap_instr, wrap_pc, wrap_pc8;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] sb_q[$];
    logic [31:0] exp_pc;

    logic        ack_en;
    int          wait_cfg;
    int          wait_cnt;

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hE1A0_0000 ^ {a[15:0], a[31:16]};
    endfunction

    // Memory model: acks after wait_cfg cycles of held request, data derived from address.
    assign imem_ack   = imem_req && ack_en && (wait_cnt >= wait_cfg);
    assign imem_rdata = instr_of(imem_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                wait_cnt <= 0;
        else if (!imem_req || imem_ack || !ack_en) wait_cnt <= 0;
        else                                       wait_cnt <= wait_cnt + 1;
    end

    fetch_stage #(.BUS(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus8    (if_pc_plus8)
    );

    // Second instance near the top of the address space, zero-wait memory, never stalled.
    fetch_stage #(.BUS(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (wrap_req),
        .imem_addr      (wrap_addr),
        .imem_ack       (wrap_req),
        .imem_rdata     (instr_of(wrap_addr)),
        .stall          (1'b0),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .if_valid       (wrap_valid),
        .if_instr       (wrap_instr),
        .if_pc          (wrap_pc),
        .if_pc_plus8    (wrap_pc8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input string tag);
        for (int i = 0; i < 20 && !imem_ack; i++) @(negedge clk);
        chk(tag, {31'b0, imem_ack}, 32'h1);
    endtask

    // Scoreboard: every instruction decode accepts must be the next expected PC.
    always @(negedge clk) begin
        if (rst_n && if_valid && !stall && !redirect_valid) begin
            chk("sb_has_entry", 32'(sb_q.size() != 0), 32'h1);
            if (sb_q.size() != 0) begin
                exp_pc = sb_q.pop_front();
                chk("sb_pc", if_pc, exp_pc);
                chk("sb_instr", if_instr, instr_of(exp_pc));
                chk("sb_pc_plus8", if_pc_plus8, exp_pc + 32'd8);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        ack_en = 1'b1; wait_cfg = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_valid", {31'b0, if_valid}, 32'h0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_pc8", if_pc_plus8, 32'h8);

        // Zero-wait run followed by a three-cycle stall while 0x10 is fetched.
        for (int a = 0; a <= 32'h14; a += 4) sb_q.push_back(32'(a));
        @(posedge clk); #1 rst_n = 1'b1;
        #1;
        chk("post_rst_req", {31'b0, imem_req}, 32'h1);
        chk("post_rst_addr", imem_addr, 32'h0);
        chk("wrap_first_addr", wrap_addr, 32'hFFFF_FFF8);
        step(); @(negedge clk);
        chk("zw_pc0", if_pc, 32'h0);
        chk("wrap_pc0", wrap_pc, 32'hFFFF_FFF8);
        step(); @(negedge clk);
        chk("zw_pc1", if_pc, 32'h4);
        chk("wrap_pc1", wrap_pc, 32'hFFFF_FFFC);
        step(); @(negedge clk);
        chk("zw_pc2", if_pc, 32'h8);
        chk("wrap_pc2", wrap_pc, 32'h0);
        step(); stall = 1'b1; @(negedge clk);
        chk("stall_addr", imem_addr, 32'h10);
        chk("stall_pc_a", if_pc, 32'hC);
        step(); @(negedge clk);
        chk("stall_req_low", {31'b0, imem_req}, 32'h0);
        chk("stall_pc_b", if_pc, 32'hC);
        step(); @(negedge clk);
        chk("stall_pc_c", if_pc, 32'hC);
        step(); stall = 1'b0; @(negedge clk);
        chk("stall_pc_d", if_pc, 32'hC);
        chk("hold_req_low", {31'b0, imem_req}, 32'h0);
        step(); @(negedge clk);
        chk("release_pc", if_pc, 32'h10);
        chk("release_req", {31'b0, imem_req}, 32'h1);
        chk("release_addr", imem_addr, 32'h14);
        step(); ack_en = 1'b0; @(negedge clk);
        chk("after_release_pc", if_pc, 32'h14);
        step(); @(negedge clk);
        chk("bubble_valid", {31'b0, if_valid}, 32'h0);
        chk("sb_drained_1", 32'(sb_q.size()), 32'h0);

        // Redirect while 0x18 is outstanding, then a redirect to 0x103 with 0x20 outstanding.
        step(); redirect_valid = 1'b1; redirect_pc = 32'h23;
        step(); redirect_valid = 1'b0; @(negedge clk);
        chk("drain1_req", {31'b0, imem_req}, 32'h1);
        chk("drain1_addr", imem_addr, 32'h18);
        chk("drain1_valid", {31'b0, if_valid}, 32'h0);
        step(); ack_en = 1'b1; @(negedge clk);
        chk("drain1_ack", {31'b0, imem_ack}, 32'h1);
        step(); ack_en = 1'b0; @(negedge clk);
        chk("redir1_addr", imem_addr, 32'h20);
        chk("redir1_valid", {31'b0, if_valid}, 32'h0);
        step(); redirect_valid = 1'b1; redirect_pc = 32'h103;
        step(); redirect_valid = 1'b0; @(negedge clk);
        chk("drain2_addr", imem_addr, 32'h20);
        sb_q.push_back(32'h100);
        sb_q.push_back(32'h104);
        ack_en = 1'b1; wait_cfg = 2;
        wait_ack("drain2_ack_timeout");
        chk("drain2_ack_addr", imem_addr, 32'h20);
        step(); @(negedge clk);
        chk("redir2_addr", imem_addr, 32'h100);
        chk("redir2_req", {31'b0, imem_req}, 32'h1);
        wait_ack("fetch100_timeout");
        step(); @(negedge clk);
        wait_ack("fetch104_timeout");
        chk("fetch104_addr", imem_addr, 32'h104);
        step(); ack_en = 1'b0; wait_cfg = 0;
        @(negedge clk);
        step(); @(negedge clk);
        chk("sb_drained_2", 32'(sb_q.size()), 32'h0);

        // Redirect, stall and ack of 0x40 all in one cycle.
        step(); redirect_valid = 1'b1; redirect_pc = 32'h40;
        step(); redirect_valid = 1'b0; ack_en = 1'b1; @(negedge clk);
        chk("rvs_drain_addr", imem_addr, 32'h108);
        step(); stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80; @(negedge clk);
        chk("rvs_setup_addr", imem_addr, 32'h40);
        chk("rvs_setup_ack", {31'b0, imem_ack}, 32'h1);
        step(); redirect_valid = 1'b0; stall = 1'b0; ack_en = 1'b0; @(negedge clk);
        chk("rvs_valid", {31'b0, if_valid}, 32'h0);
        chk("rvs_addr", imem_addr, 32'h80);
        chk("rvs_req", {31'b0, imem_req}, 32'h1);

        // Reach HOLD, then pulse reset in the middle of it.
        step(); ack_en = 1'b1;
        step(); stall = 1'b1; @(negedge clk);
        chk("hold_setup_pc", if_pc, 32'h80);
        step(); @(negedge clk);
        chk("hold_setup_req", {31'b0, imem_req}, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, if_valid}, 32'h0);
        chk("midrst_instr", if_instr, 32'h0);
        chk("midrst_pc", if_pc, 32'h0);
        chk("midrst_pc8", if_pc_plus8, 32'h8);
        chk("midrst_req", {31'b0, imem_req}, 32'h0);
        stall = 1'b0;
        sb_q.push_back(32'h0);
        sb_q.push_back(32'h4);
        step(); step();
        rst_n = 1'b1;
        #1;
        chk("restart_req", {31'b0, imem_req}, 32'h1);
        chk("restart_addr", imem_addr, 32'h0);
        step();
        step(); ack_en = 1'b0;
        step(); @(negedge clk);
        chk("sb_drained_3", 32'(sb_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
